// File: rtl/perip_bus_pkg.sv
// Shared constants and FSM encoding for the peripheral bus arbiter.
// The optional PERIP_BUS_ARBITER_LOCK_EN feature lives in perip_bus_arbiter.sv.
package perip_bus_pkg;

    localparam int PERIP_DATA_W = 32;
    localparam int PERIP_BE_W   = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_e;

    // Index width that stays legal (>= 1 bit) for a single requester.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/perip_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr_i,
// wrapping to the lowest set request when none lies above the pointer.
module rr_pick
    import perip_bus_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               any_o
);

    logic [NUM_REQ-1:0] upper;

    always_comb begin
        upper = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            upper[i] = req_i[i] && (IDX_W'(i) >= ptr_i);
        end
    end

    // Lowest set request overall, then overridden by the lowest one at/above ptr.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                gnt_o    = '0;
                gnt_o[i] = 1'b1;
                idx_o    = IDX_W'(i);
            end
        end
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (upper[i]) begin
                gnt_o    = '0;
                gnt_o[i] = 1'b1;
                idx_o    = IDX_W'(i);
            end
        end
    end

    assign any_o = |req_i;

endmodule

// File: rtl/perip_bus_arbiter.sv
// Round-robin arbiter sharing one register-style peripheral port among NUM_REQ masters.
// Define PERIP_BUS_ARBITER_LOCK_EN to add lock_i for atomic back-to-back ownership.
module perip_bus_arbiter
    import perip_bus_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 6
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [NUM_REQ-1:0]               req_i,
    input  logic [NUM_REQ-1:0]               write_i,
    input  logic [PERIP_BE_W*NUM_REQ-1:0]    be_i,
    input  logic [ADDR_W*NUM_REQ-1:0]        addr_i,
    input  logic [PERIP_DATA_W*NUM_REQ-1:0]  wdata_i,
`ifdef PERIP_BUS_ARBITER_LOCK_EN
    input  logic [NUM_REQ-1:0]               lock_i,
`endif
    output logic [NUM_REQ-1:0]               gnt_o,
    output logic [NUM_REQ-1:0]               rvalid_o,
    output logic [PERIP_DATA_W-1:0]          rdata_o,
    output logic                             perip_write_o,
    output logic [PERIP_BE_W-1:0]            perip_be_o,
    output logic [ADDR_W-1:0]                perip_addr_o,
    output logic [PERIP_DATA_W-1:0]          perip_wdata_o,
    input  logic [PERIP_DATA_W-1:0]          perip_rdata_i
);

    localparam int IDX_W = idx_width(NUM_REQ);

    arb_state_e              state_q, state_d;
    logic [IDX_W-1:0]        ptr_q, ptr_d;
    logic [IDX_W-1:0]        owner_q, owner_d;
    logic                    perip_write_q, perip_write_d;
    logic [PERIP_BE_W-1:0]   perip_be_q, perip_be_d;
    logic [ADDR_W-1:0]       perip_addr_q, perip_addr_d;
    logic [PERIP_DATA_W-1:0] perip_wdata_q, perip_wdata_d;
    logic [PERIP_DATA_W-1:0] rdata_q, rdata_d;

    logic [NUM_REQ-1:0]      pick_gnt;
    logic [IDX_W-1:0]        pick_idx;
    logic                    pick_any;
    logic [NUM_REQ-1:0]      owner_oh;
    logic [NUM_REQ-1:0]      win_gnt;
    logic [IDX_W-1:0]        win_idx;
    logic                    lock_hit;
    logic                    hold_ptr;

    logic                    sel_write;
    logic [PERIP_BE_W-1:0]   sel_be;
    logic [ADDR_W-1:0]       sel_addr;
    logic [PERIP_DATA_W-1:0] sel_wdata;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req_i (req_i),
        .ptr_i (ptr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    assign owner_oh = NUM_REQ'(1) << owner_q;

`ifdef PERIP_BUS_ARBITER_LOCK_EN
    // Lock is sampled in RESP and only honoured in the very next IDLE cycle.
    logic lock_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lock_q <= 1'b0;
        end else if (state_q == RESP) begin
            lock_q <= lock_i[owner_q];
        end else if (state_q == IDLE) begin
            lock_q <= 1'b0;
        end
    end

    assign lock_hit = lock_q & req_i[owner_q];
    assign hold_ptr = lock_i[owner_q];
`else
    assign lock_hit = 1'b0;
    assign hold_ptr = 1'b0;
`endif

    assign win_gnt = lock_hit ? owner_oh : pick_gnt;
    assign win_idx = lock_hit ? owner_q  : pick_idx;

    always_comb begin
        sel_write = 1'b0;
        sel_be    = '0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_gnt[i]) begin
                sel_write = write_i[i];
                sel_be    = be_i[i*PERIP_BE_W +: PERIP_BE_W];
                sel_addr  = addr_i[i*ADDR_W +: ADDR_W];
                sel_wdata = wdata_i[i*PERIP_DATA_W +: PERIP_DATA_W];
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        owner_d       = owner_q;
        perip_write_d = perip_write_q;
        perip_be_d    = perip_be_q;
        perip_addr_d  = perip_addr_q;
        perip_wdata_d = perip_wdata_q;
        rdata_d       = rdata_q;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d       = ACCESS;
                    owner_d       = win_idx;
                    perip_write_d = sel_write;
                    perip_be_d    = sel_be;
                    perip_addr_d  = sel_addr;
                    perip_wdata_d = sel_wdata;
                end
            end
            ACCESS: begin
                state_d       = RESP;
                perip_write_d = 1'b0;
                perip_be_d    = '0;
                rdata_d       = perip_rdata_i;
            end
            RESP: begin
                state_d = IDLE;
                if (!hold_ptr) begin
                    ptr_d = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            owner_q       <= '0;
            perip_write_q <= 1'b0;
            perip_be_q    <= '0;
            perip_addr_q  <= '0;
            perip_wdata_q <= '0;
            rdata_q       <= '0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            owner_q       <= owner_d;
            perip_write_q <= perip_write_d;
            perip_be_q    <= perip_be_d;
            perip_addr_q  <= perip_addr_d;
            perip_wdata_q <= perip_wdata_d;
            rdata_q       <= rdata_d;
        end
    end

    assign gnt_o         = (state_q != IDLE) ? owner_oh : '0;
    assign rvalid_o      = (state_q == RESP) ? owner_oh : '0;
    assign rdata_o       = rdata_q;
    assign perip_write_o = perip_write_q;
    assign perip_be_o    = perip_be_q;
    assign perip_addr_o  = perip_addr_q;
    assign perip_wdata_o = perip_wdata_q;

endmodule

// File: tb/tb_perip_bus_arbiter.sv
// Directed, table-driven bench for perip_bus_arbiter (NUM_REQ = 2, ADDR_W = 6).
module tb_perip_bus_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [1:0]  req_i;
    logic [1:0]  write_i;
    logic [7:0]  be_i;
    logic [11:0] addr_i;
    logic [63:0] wdata_i;
`ifdef PERIP_BUS_ARBITER_LOCK_EN
    logic [1:0]  lock_i;
`endif
    logic [1:0]  gnt_o;
    logic [1:0]  rvalid_o;
    logic [31:0] rdata_o;
    logic        perip_write_o;
    logic [3:0]  perip_be_o;
    logic [5:0]  perip_addr_o;
    logic [31:0] perip_wdata_o;
    logic [31:0] perip_rdata_i;

    int checks = 0;
    int errors = 0;

    perip_bus_arbiter #(.NUM_REQ(2), .ADDR_W(6)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .req_i         (req_i),
        .write_i       (write_i),
        .be_i          (be_i),
        .addr_i        (addr_i),
        .wdata_i       (wdata_i),
`ifdef PERIP_BUS_ARBITER_LOCK_EN
        .lock_i        (lock_i),
`endif
        .gnt_o         (gnt_o),
        .rvalid_o      (rvalid_o),
        .rdata_o       (rdata_o),
        .perip_write_o (perip_write_o),
        .perip_be_o    (perip_be_o),
        .perip_addr_o  (perip_addr_o),
        .perip_wdata_o (perip_wdata_o),
        .perip_rdata_i (perip_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int          who;
        logic        wr;
        logic [3:0]  be;
        logic [5:0]  addr;
        logic [31:0] wdata;
        logic [31:0] prdata;
        logic [1:0]  exp_gnt;
        logic        exp_wr;
        logic [3:0]  exp_be;
        logic [5:0]  exp_addr;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[4];
    logic [1:0] exp_q[$];

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Owner gets the vector's fields; the other requester gets the complement.
    task automatic drive_vec(input vec_t v);
        req_i = 2'b00;
        req_i[v.who] = 1'b1;
        for (int k = 0; k < 2; k++) begin
            if (k == v.who) begin
                write_i[k]        = v.wr;
                be_i[k*4 +: 4]    = v.be;
                addr_i[k*6 +: 6]  = v.addr;
                wdata_i[k*32 +: 32] = v.wdata;
            end else begin
                write_i[k]        = ~v.wr;
                be_i[k*4 +: 4]    = ~v.be;
                addr_i[k*6 +: 6]  = ~v.addr;
                wdata_i[k*32 +: 32] = ~v.wdata;
            end
        end
        perip_rdata_i = v.prdata;
    endtask

    task automatic run_vec(input vec_t v);
        drive_vec(v);
        tick();
        chk("acc_gnt", 32'(gnt_o), 32'(v.exp_gnt));
        chk("acc_rvalid", 32'(rvalid_o), 32'd0);
        chk("acc_write", 32'(perip_write_o), 32'(v.exp_wr));
        chk("acc_be", 32'(perip_be_o), 32'(v.exp_be));
        chk("acc_addr", 32'(perip_addr_o), 32'(v.exp_addr));
        chk("acc_wdata", perip_wdata_o, v.exp_wdata);
        // Command must not follow inputs after the capture edge.
        write_i = 2'($urandom_range(0, 3));
        be_i    = 8'($urandom_range(0, 255));
        addr_i  = 12'($urandom_range(0, 4095));
        wdata_i = {$urandom, $urandom};
        tick();
        chk("resp_rvalid", 32'(rvalid_o), 32'(v.exp_gnt));
        chk("resp_gnt", 32'(gnt_o), 32'(v.exp_gnt));
        chk("resp_rdata", rdata_o, v.exp_rdata);
        chk("resp_write", 32'(perip_write_o), 32'd0);
        chk("resp_be", 32'(perip_be_o), 32'd0);
        chk("resp_addr_held", 32'(perip_addr_o), 32'(v.exp_addr));
        req_i = 2'b00;
        tick();
        chk("idle_gnt", 32'(gnt_o), 32'd0);
        chk("idle_rvalid", 32'(rvalid_o), 32'd0);
    endtask

    initial begin
        logic [1:0] cont_gnt[12];

        vecs[0] = '{0, 1'b0, 4'hF, 6'h00, 32'hDEAD_0000, 32'h0000_A55A,
                    2'b01, 1'b0, 4'hF, 6'h00, 32'hDEAD_0000, 32'h0000_A55A};
        vecs[1] = '{1, 1'b1, 4'h3, 6'h04, 32'h0000_1234, 32'hCAFE_F00D,
                    2'b10, 1'b1, 4'h3, 6'h04, 32'h0000_1234, 32'hCAFE_F00D};
        vecs[2] = '{0, 1'b1, 4'h8, 6'h3F, 32'hFFFF_FFFF, 32'h0000_0000,
                    2'b01, 1'b1, 4'h8, 6'h3F, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[3] = '{1, 1'b0, 4'h5, 6'h2A, 32'h0F0F_0F0F, 32'h1234_5678,
                    2'b10, 1'b0, 4'h5, 6'h2A, 32'h0F0F_0F0F, 32'h1234_5678};
        cont_gnt = '{2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00,
                     2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00};

        rst_i = 1'b1;
        req_i = '0;
        write_i = '0;
        be_i = '0;
        addr_i = '0;
        wdata_i = '0;
        perip_rdata_i = '0;
`ifdef PERIP_BUS_ARBITER_LOCK_EN
        lock_i = '0;
`endif
        tick();
        tick();
        rst_i = 1'b0;
        chk("rst_gnt", 32'(gnt_o), 32'd0);
        chk("rst_rvalid", 32'(rvalid_o), 32'd0);
        chk("rst_rdata", rdata_o, 32'd0);
        chk("rst_write", 32'(perip_write_o), 32'd0);
        chk("rst_be", 32'(perip_be_o), 32'd0);
        chk("rst_addr", 32'(perip_addr_o), 32'd0);
        chk("rst_wdata", perip_wdata_o, 32'd0);
        tick();
        tick();
        chk("noreq_gnt", 32'(gnt_o), 32'd0);
        chk("noreq_write", 32'(perip_write_o), 32'd0);

        for (int i = 0; i < 4; i++) begin
            run_vec(vecs[i]);
        end

        // Contention: both requesting continuously, pointer starts at 0.
        exp_q = '{2'b01, 2'b10, 2'b01, 2'b10};
        req_i = 2'b11;
        write_i = 2'b00;
        for (int t = 0; t < 12; t++) begin
            tick();
            chk("cont_gnt", 32'(gnt_o), 32'(cont_gnt[t]));
            if (rvalid_o != 2'b00) begin
                if (exp_q.size() == 0) begin
                    chk("cont_extra_rvalid", 32'(rvalid_o), 32'd0);
                end else begin
                    chk("cont_rvalid", 32'(rvalid_o), 32'(exp_q.pop_front()));
                end
            end
        end
        chk("cont_pending", 32'(exp_q.size()), 32'd0);
        req_i = 2'b00;
        tick();

        // Requester 0 drops its request right after capture.
        req_i = 2'b11;
        tick();
        chk("drop_gnt0", 32'(gnt_o), 32'(2'b01));
        req_i = 2'b10;
        tick();
        chk("drop_rvalid0", 32'(rvalid_o), 32'(2'b01));
        tick();
        chk("drop_idle", 32'(gnt_o), 32'd0);
        tick();
        chk("drop_next_gnt1", 32'(gnt_o), 32'(2'b10));
        tick();
        chk("drop_rvalid1", 32'(rvalid_o), 32'(2'b10));
        req_i = 2'b00;
        tick();

        // Reset during ACCESS of a write; pointer is 1 before reset.
        run_vec(vecs[0]);
        req_i = 2'b10;
        write_i = 2'b10;
        be_i = 8'hC0;
        addr_i = {6'h11, 6'h00};
        wdata_i = {32'h0000_55AA, 32'h0};
        perip_rdata_i = 32'hBEEF_0001;
        tick();
        chk("rstop_write", 32'(perip_write_o), 32'd1);
        chk("rstop_gnt", 32'(gnt_o), 32'(2'b10));
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        req_i = 2'b00;
        chk("rstop_gnt0", 32'(gnt_o), 32'd0);
        chk("rstop_rvalid0", 32'(rvalid_o), 32'd0);
        chk("rstop_write0", 32'(perip_write_o), 32'd0);
        chk("rstop_be0", 32'(perip_be_o), 32'd0);
        chk("rstop_addr0", 32'(perip_addr_o), 32'd0);
        chk("rstop_wdata0", perip_wdata_o, 32'd0);
        chk("rstop_rdata0", rdata_o, 32'd0);
        tick();
        chk("rstop_nowrite1", 32'(perip_write_o), 32'd0);
        tick();
        chk("rstop_nowrite2", 32'(perip_write_o), 32'd0);
        req_i = 2'b11;
        tick();
        chk("rstop_ptr0", 32'(gnt_o), 32'(2'b01));
        tick();
        chk("rstop_rvalid", 32'(rvalid_o), 32'(2'b01));
        req_i = 2'b00;
        tick();

`ifdef PERIP_BUS_ARBITER_LOCK_EN
        // Pointer is 1 here; lock keeps requester 0 despite requester 1 waiting.
        req_i = 2'b01;
        lock_i = 2'b01;
        tick();
        chk("lock_gnt_a", 32'(gnt_o), 32'(2'b01));
        tick();
        chk("lock_rvalid_a", 32'(rvalid_o), 32'(2'b01));
        req_i = 2'b11;
        tick();
        tick();
        chk("lock_gnt_b", 32'(gnt_o), 32'(2'b01));
        lock_i = 2'b00;
        tick();
        chk("lock_rvalid_b", 32'(rvalid_o), 32'(2'b01));
        tick();
        tick();
        chk("lock_release_gnt", 32'(gnt_o), 32'(2'b10));
        tick();
        chk("lock_release_rvalid", 32'(rvalid_o), 32'(2'b10));
        req_i = 2'b00;
        tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
